// File: rtl/conv_window_stream_if.sv
// Row-write and window-stream bundle between the frame source, the window buffer and the MAC array.
// slave = window buffer side, master = source/consumer side.
interface conv_window_stream_if #(
  parameter int IMAGE_SIZE  = 16,
  parameter int IMAGE_ROWS  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16
);
  logic                                        wr_en;
  logic [IMAGE_SIZE*DATA_WIDTH-1:0]            data_in;
  logic                                        full;
  logic                                        ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_out;
  logic                                        win_valid;
  logic                                        win_ready;
  logic [$clog2(IMAGE_ROWS)-1:0]               row_idx;
  logic [$clog2(IMAGE_SIZE)-1:0]               col_idx;
  logic                                        frame_done;

  modport slave (
    input  wr_en, data_in, ready, win_ready,
    output full, win_out, win_valid, row_idx, col_idx, frame_done
  );

  modport master (
    output wr_en, data_in, ready, win_ready,
    input  full, win_out, win_valid, row_idx, col_idx, frame_done
  );
endinterface

// File: rtl/conv_window_stream.sv
// Circular buffer of KERNEL_SIZE+STRIDE full-width rows streaming every KxK window of a frame.
// Window registered one cycle after leaving IDLE; win_out held while win_ready is low; full refuses rows.
module conv_window_stream #(
  parameter int IMAGE_SIZE  = 16,
  parameter int IMAGE_ROWS  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int STRIDE      = 1
) (
  input  logic                clk,
  input  logic                rst,
  conv_window_stream_if.slave bus
);
  localparam int ROW_BUF  = KERNEL_SIZE + STRIDE;
  localparam int RW       = IMAGE_SIZE * DATA_WIDTH;
  localparam int WW       = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
  localparam int PW       = $clog2(ROW_BUF);
  localparam int SW       = $clog2(ROW_BUF + 1);
  localparam int IW       = $clog2(IMAGE_ROWS + 1);
  localparam int RIW      = $clog2(IMAGE_ROWS);
  localparam int CIW      = $clog2(IMAGE_SIZE);
  localparam int COL_LAST = IMAGE_SIZE - KERNEL_SIZE;
  localparam int ROW_LAST = IMAGE_ROWS - KERNEL_SIZE;

  typedef enum logic [1:0] {IDLE, SWEEP, ADVANCE, DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [RW-1:0]  r_buf [ROW_BUF];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_base;
  logic [SW-1:0]  r_rows_stored, w_stored_nxt;
  logic [IW-1:0]  r_rows_in;
  logic [RIW-1:0] r_row;
  logic [CIW-1:0] r_col, w_col_load;
  logic [WW-1:0]  r_win, w_win;
  logic           r_win_valid;
  logic           w_full, w_wr_acc, w_load, w_release, w_flush, w_hs;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= ROW_BUF) s = s - ROW_BUF;
    return PW'(s);
  endfunction

  assign w_full   = (r_rows_stored == SW'(ROW_BUF)) || (r_rows_in == IW'(IMAGE_ROWS)) ||
                    (r_state == DONE);
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_hs     = r_win_valid && bus.win_ready;
  assign w_stored_nxt = SW'(int'(r_rows_stored) + (w_wr_acc ? 1 : 0) - (w_release ? STRIDE : 0));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_flush     = 1'b0;
    w_col_load  = r_col;
    w_rd_base   = r_rd_ptr;
    case (r_state)
      IDLE: begin
        if (bus.ready && (r_rows_stored >= SW'(KERNEL_SIZE))) begin
          w_state_nxt = SWEEP;
          w_load      = 1'b1;
        end
      end
      SWEEP: begin
        if (w_hs) begin
          if (int'(r_col) + STRIDE <= COL_LAST) begin
            w_load     = 1'b1;
            w_col_load = r_col + CIW'(STRIDE);
          end else begin
            w_state_nxt = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        // Release STRIDE rows; a chained window reads from the post-release read pointer.
        w_release  = 1'b1;
        w_col_load = '0;
        w_rd_base  = ptr_add(r_rd_ptr, STRIDE);
        if (int'(r_row) + STRIDE > ROW_LAST) begin
          w_state_nxt = DONE;
        end else if (bus.ready && (int'(r_rows_stored) - STRIDE >= KERNEL_SIZE)) begin
          w_state_nxt = SWEEP;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        w_flush     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        w_win[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] =
          r_buf[ptr_add(w_rd_base, r)][(int'(w_col_load)+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) r_buf[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rows_stored <= '0;
      r_rows_in     <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_win         <= '0;
      r_win_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_win       <= w_win;
        r_win_valid <= 1'b1;
      end else if (w_hs) begin
        r_win_valid <= 1'b0;
      end
      if (w_flush) begin
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_rows_stored <= '0;
        r_rows_in     <= '0;
        r_row         <= '0;
        r_col         <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr  <= ptr_add(r_wr_ptr, 1);
          r_rows_in <= r_rows_in + IW'(1);
        end
        r_rows_stored <= w_stored_nxt;
        if (w_release) r_rd_ptr <= w_rd_base;
        // The final release keeps the last row index so row_idx never wraps before the flush.
        if (w_release && (w_state_nxt != DONE)) r_row <= r_row + RIW'(STRIDE);
        if (w_load || w_release) r_col <= w_col_load;
      end
    end
  end

  assign bus.full       = w_full;
  assign bus.win_out    = r_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.row_idx    = r_row;
  assign bus.col_idx    = r_col;
  assign bus.frame_done = (r_state == DONE);
endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
- Parametrised successor to the ping/pong convolution memory bank.
- Accepts image rows, one full row per write cycle with all pixels presented in parallel, into a circular buffer of KERNEL_SIZE+STRIDE rows.
- Streams every KERNEL_SIZE x KERNEL_SIZE window of the frame, with configurable stride, over a valid/ready handshake to the convolution MAC array.
- Generalises image width, frame height, kernel size and stride; adds back-pressure, a full flag and end-of-frame signalling.

Parameters:
IMAGE_SIZE, 16, pixels per row (row width)
IMAGE_ROWS, 16, rows per frame
KERNEL_SIZE, 3, window edge length (>=2, <=IMAGE_SIZE, <=IMAGE_ROWS)
DATA_WIDTH, 16, bits per pixel (FP16 container)
STRIDE, 1, horizontal and vertical window step (>=1, <=KERNEL_SIZE)
ROW_BUF, KERNEL_SIZE+STRIDE, rows held in the circular buffer (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
wr_en  in  1  write request for one full row
data_in  in  IMAGE_SIZE*DATA_WIDTH  row pixels; pixel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
full  out  1  row write will be refused this cycle
ready  in  1  read engine enable, sampled only in IDLE
win_out  out  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  window; element (r,c) at bits [(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
win_valid  out  1  win_out holds a valid window
win_ready  in  1  consumer accepts the window
row_idx  out  clog2(IMAGE_ROWS)  top image row of the current window
col_idx  out  clog2(IMAGE_SIZE)  left image column of the current window
frame_done  out  1  one-cycle pulse after the last window of the frame is accepted

Behaviour:
- Reset (rst==0 at an edge): outputs go to 0 (full, win_valid, win_out, row_idx, col_idx, frame_done); pointers, rows_stored, rows_in and FSM go to 0/IDLE. This applies mid-sweep too; the in-flight window is dropped and no frame_done pulses.
- Write acceptance: a row is accepted when wr_en && !full.
  - Row is stored at wr_ptr; wr_ptr wraps modulo ROW_BUF.
  - rows_stored and rows_in both increment.
- full is combinational: (rows_stored==ROW_BUF) || (rows_in==IMAGE_ROWS). Refused writes are silently dropped.
- FSM states are IDLE, SWEEP, ADVANCE, DONE.
  - IDLE -> SWEEP when ready && rows_stored >= KERNEL_SIZE. The window at col 0 is registered on that edge, so win_valid=1 on the next cycle (1-cycle latency).
  - SWEEP, on each win_valid && win_ready:
    - if col+STRIDE <= IMAGE_SIZE-KERNEL_SIZE: col += STRIDE and the next window is registered on the same edge (no bubble).
    - otherwise: go to ADVANCE with win_valid=0.
  - SWEEP with win_valid && !win_ready: win_out, row_idx and col_idx are held stable.
  - ADVANCE (one cycle): rd_ptr += STRIDE modulo ROW_BUF, rows_stored -= STRIDE, row += STRIDE, col=0.
    - if the new row > IMAGE_ROWS-KERNEL_SIZE: go to DONE.
    - else if ready && rows_stored(after release) >= KERNEL_SIZE: go to SWEEP.
    - else go to IDLE. Deasserting ready therefore pauses the sweep at a row boundary only.
  - DONE (one cycle): frame_done=1; flush pointers, rows_stored, rows_in, row and col to 0; go to IDLE.
- Simultaneous write and release in ADVANCE: rows_stored_next = rows_stored + 1 - STRIDE. A write in ADVANCE lands in a slot not being read.
- Window element (r,c) = buffer row (rd_ptr+r) mod ROW_BUF, pixel col+c.
- Windows per row = (IMAGE_SIZE-KERNEL_SIZE)/STRIDE+1. Window rows per frame = (IMAGE_ROWS-KERNEL_SIZE)/STRIDE+1. Rows left over by stride are discarded at DONE.
- Writes are accepted in every state except DONE, where full=1.

Test Plan:
- Defaults, pixel (r,c)=16r+c, rows written back-to-back, ready=1, win_ready=1 -> first window {0,1,2,16,17,18,32,33,34} at row_idx=0, col_idx=0. Exactly 196 windows; the last is {221,222,223,237,238,239,253,254,255} at (13,13). One frame_done pulse.
- ready=0 while writing 5 rows -> full rises after the 4th accepted row; the 5th is dropped. After ready=1, window (0,0) is as above and no window contains the dropped row.
- win_ready toggled 1/0 per cycle (or random) -> win_out stable while stalled. The window sequence is identical to the unstalled run: 196 windows, no duplicates or gaps.
- STRIDE=2, same data -> 7 windows per row, 49 in total. Second window = {2,3,4,18,19,20,34,35,36}. Second window row starts at row_idx=2. ROW_BUF=5.
- ready dropped mid-sweep of window row 0 -> all 14 row-0 windows complete. Then FSM sits in IDLE with win_valid=0, and resumes at row_idx=1, col_idx=0 when ready=1.
- rst=0 during SWEEP at window (3,5) -> next cycle win_valid=0, full=0, no frame_done. Rewriting the frame reproduces the first scenario exactly.
